// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared parameters and FSM state type for the spiking PE row accumulator
package snn_pkg;
    localparam int WIDTH      = 8;
    localparam int DEPTH_F    = 5;
    localparam int PACK_WIDTH = 64;
    localparam int PSUM_WIDTH = 13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WREADY = 2'd1,
        ST_ACC    = 2'd2,
        ST_OUT    = 2'd3
    } pe_state_e;
endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - unsigned adder that clamps at the all-ones value of the wider operand
module sat_add #(
    parameter int AW = 13,
    parameter int BW = 8
) (
    input  logic [AW-1:0] a_i,
    input  logic [BW-1:0] b_i,
    output logic [AW-1:0] sum_o
);
    logic [AW:0] full;

    assign full  = {1'b0, a_i} + {{(AW + 1 - BW){1'b0}}, b_i};
    assign sum_o = full[AW] ? {AW{1'b1}} : full[AW-1:0];
endmodule

// File: rtl/pe_row_acc.sv
// rtl/pe_row_acc.sv - one PE row: spike-gated weight accumulation onto an upstream partial sum
module pe_row_acc #(
    parameter int WIDTH      = snn_pkg::WIDTH,
    parameter int DEPTH_F    = snn_pkg::DEPTH_F,
    parameter int PACK_WIDTH = snn_pkg::PACK_WIDTH,
    parameter int PSUM_WIDTH = snn_pkg::PSUM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  filt_valid,
    output logic                  filt_ready,
    input  logic [PACK_WIDTH-1:0] filt_data,
    input  logic                  spk_valid,
    output logic                  spk_ready,
    input  logic [DEPTH_F-1:0]    spk_data,
    input  logic                  psin_valid,
    output logic                  psin_ready,
    input  logic [PSUM_WIDTH-1:0] psin_data,
    output logic                  ps_valid,
    input  logic                  ps_ready,
    output logic [PSUM_WIDTH-1:0] ps_data,
    output logic                  busy
);
    import snn_pkg::*;

    localparam int CW = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;

    pe_state_e             state_q, state_d;
    logic [WIDTH-1:0]      w_q [DEPTH_F];
    logic [DEPTH_F-1:0]    spk_q, spk_d;
    logic [PSUM_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ld_w;
    logic                  filt_rdy_c, joint_rdy_c, ps_vld_c, busy_c;
    logic [WIDTH-1:0]      addend;
    logic [PSUM_WIDTH-1:0] acc_sum;
    logic                  unused_filt_bits;

    assign unused_filt_bits = ^filt_data[PACK_WIDTH-1:WIDTH*DEPTH_F];

    assign addend = spk_q[cnt_q] ? w_q[cnt_q] : '0;

    sat_add #(.AW(PSUM_WIDTH), .BW(WIDTH)) u_sat_add (
        .a_i   (acc_q),
        .b_i   (addend),
        .sum_o (acc_sum)
    );

    always_comb begin
        state_d     = state_q;
        spk_d       = spk_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ld_w        = 1'b0;
        filt_rdy_c  = 1'b0;
        joint_rdy_c = 1'b0;
        ps_vld_c    = 1'b0;
        busy_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                filt_rdy_c = 1'b1;
                if (filt_valid) begin
                    ld_w    = 1'b1;
                    state_d = ST_WREADY;
                end
            end
            ST_WREADY: begin
                filt_rdy_c = 1'b1;
                // A pending filter always wins; spikes and psum only move together.
                if (filt_valid) begin
                    ld_w = 1'b1;
                end else if (spk_valid && psin_valid) begin
                    joint_rdy_c = 1'b1;
                    spk_d       = spk_data;
                    acc_d       = psin_data;
                    cnt_d       = '0;
                    state_d     = ST_ACC;
                end
            end
            ST_ACC: begin
                busy_c = 1'b1;
                acc_d  = acc_sum;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(DEPTH_F - 1)) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                busy_c   = 1'b1;
                ps_vld_c = 1'b1;
                if (ps_ready) begin
                    state_d = ST_WREADY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced low combinationally while reset is asserted.
    assign filt_ready = rst_n && filt_rdy_c;
    assign spk_ready  = rst_n && joint_rdy_c;
    assign psin_ready = rst_n && joint_rdy_c;
    assign ps_valid   = rst_n && ps_vld_c;
    assign busy       = rst_n && busy_c;
    assign ps_data    = (rst_n && ps_vld_c) ? acc_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            spk_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH_F; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            spk_q   <= spk_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            if (ld_w) begin
                for (int i = 0; i < DEPTH_F; i++) begin
                    w_q[i] <= filt_data[WIDTH*i +: WIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_pe_row_acc.sv
// tb/tb_pe_row_acc.sv - randomized self-checking bench for pe_row_acc against a saturating sum model
module tb_pe_row_acc;
    localparam int NF   = 5;
    localparam int PMAX = 8191;

    logic        clk;
    logic        rst_n;
    logic        filt_valid;
    logic        filt_ready;
    logic [63:0] filt_data;
    logic        spk_valid;
    logic        spk_ready;
    logic [4:0]  spk_data;
    logic        psin_valid;
    logic        psin_ready;
    logic [12:0] psin_data;
    logic        ps_valid;
    logic        ps_ready;
    logic [12:0] ps_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int mw [NF];

    pe_row_acc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .filt_valid (filt_valid),
        .filt_ready (filt_ready),
        .filt_data  (filt_data),
        .spk_valid  (spk_valid),
        .spk_ready  (spk_ready),
        .spk_data   (spk_data),
        .psin_valid (psin_valid),
        .psin_ready (psin_ready),
        .psin_data  (psin_data),
        .ps_valid   (ps_valid),
        .ps_ready   (ps_ready),
        .ps_data    (ps_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_psum(input logic [4:0] s, input int p);
        int t;
        t = p;
        for (int i = 0; i < NF; i++) begin
            if (s[i]) t += mw[i];
        end
        return (t > PMAX) ? PMAX : t;
    endfunction

    task automatic load_filter(input int w0, input int w1, input int w2, input int w3, input int w4);
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[7:0]   = w0[7:0];
        d[15:8]  = w1[7:0];
        d[23:16] = w2[7:0];
        d[31:24] = w3[7:0];
        d[39:32] = w4[7:0];
        filt_data  = d;
        filt_valid = 1'b1;
        #1;
        check("filt_ready_on_load", filt_ready, 1);
        @(posedge clk);
        #1;
        filt_valid = 1'b0;
        mw[0] = w0; mw[1] = w1; mw[2] = w2; mw[3] = w3; mw[4] = w4;
    endtask

    task automatic run_row(input logic [4:0] s, input int p, input int hold, input string tag);
        int  exp;
        int  lat;
        bit  got;
        exp        = model_psum(s, p);
        spk_data   = s;
        psin_data  = p[12:0];
        spk_valid  = 1'b1;
        psin_valid = 1'b1;
        #1;
        check({tag, "_spk_ready"}, spk_ready, 1);
        check({tag, "_psin_ready"}, psin_ready, 1);
        @(posedge clk);
        #1;
        spk_valid  = 1'b0;
        psin_valid = 1'b0;
        check({tag, "_busy_acc"}, busy, 1);
        check({tag, "_filt_ready_acc"}, filt_ready, 0);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ps_valid) begin
                got = 1'b1;
                lat = k;
            end
        end
        if (!got) begin
            check({tag, "_ps_valid_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, lat, NF);
            check({tag, "_ps_data"}, ps_data, exp);
            if (hold > 0) begin
                spk_valid  = 1'b1;
                psin_valid = 1'b1;
                filt_valid = 1'b1;
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check({tag, "_hold_valid"}, ps_valid, 1);
                    check({tag, "_hold_data"}, ps_data, exp);
                    check({tag, "_hold_spk_ready"}, spk_ready, 0);
                    check({tag, "_hold_psin_ready"}, psin_ready, 0);
                    check({tag, "_hold_filt_ready"}, filt_ready, 0);
                end
                spk_valid  = 1'b0;
                psin_valid = 1'b0;
                filt_valid = 1'b0;
            end
            ps_ready = 1'b1;
            @(posedge clk);
            #1;
            ps_ready = 1'b0;
            check({tag, "_ps_valid_drop"}, ps_valid, 0);
            check({tag, "_busy_drop"}, busy, 0);
            check({tag, "_filt_ready_back"}, filt_ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        filt_valid = 1'b0;
        filt_data  = '0;
        spk_valid  = 1'b0;
        spk_data   = '0;
        psin_valid = 1'b0;
        psin_data  = '0;
        ps_ready   = 1'b0;
        for (int i = 0; i < NF; i++) mw[i] = 0;
        #3;
        check("rst_filt_ready", filt_ready, 0);
        check("rst_spk_ready", spk_ready, 0);
        check("rst_psin_ready", psin_ready, 0);
        check("rst_ps_valid", ps_valid, 0);
        check("rst_ps_data", ps_data, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("idle_filt_ready", filt_ready, 1);
        spk_valid  = 1'b1;
        psin_valid = 1'b1;
        #1;
        check("idle_spk_ready", spk_ready, 0);
        spk_valid  = 1'b0;
        psin_valid = 1'b0;

        load_filter(1, 2, 3, 4, 5);
        run_row(5'b10101, 10, 0, "basic");
        check("basic_literal", model_psum(5'b10101, 10), 19);
        run_row(5'b00000, 100, 0, "zero_spk");
        run_row(5'b10101, 10, 4, "hold");
        load_filter(255, 255, 255, 255, 255);
        run_row(5'b11111, 8000, 0, "saturate");

        // Filter and joint spike/psum offered in the same WREADY cycle.
        filt_data  = 64'h0000000A0A0A0A0A;
        filt_valid = 1'b1;
        spk_data   = 5'b00011;
        psin_data  = '0;
        spk_valid  = 1'b1;
        psin_valid = 1'b1;
        #1;
        check("prio_filt_ready", filt_ready, 1);
        check("prio_spk_ready", spk_ready, 0);
        check("prio_psin_ready", psin_ready, 0);
        @(posedge clk);
        #1;
        filt_valid = 1'b0;
        check("prio_no_busy", busy, 0);
        for (int i = 0; i < NF; i++) mw[i] = 10;
        run_row(5'b00011, 0, 0, "prio");

        // Reset while accumulating column 2.
        load_filter(1, 2, 3, 4, 5);
        spk_data   = 5'b11111;
        psin_data  = 13'd50;
        spk_valid  = 1'b1;
        psin_valid = 1'b1;
        @(posedge clk);
        #1;
        spk_valid  = 1'b0;
        psin_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_filt_ready", filt_ready, 0);
        check("mid_rst_spk_ready", spk_ready, 0);
        check("mid_rst_ps_valid", ps_valid, 0);
        check("mid_rst_ps_data", ps_data, 0);
        check("mid_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NF; i++) mw[i] = 0;
        spk_valid  = 1'b1;
        psin_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_rst_spk_ready", spk_ready, 0);
            check("post_rst_ps_valid", ps_valid, 0);
            check("post_rst_busy", busy, 0);
        end
        spk_valid  = 1'b0;
        psin_valid = 1'b0;
        load_filter(7, 0, 9, 1, 3);
        run_row(5'b01101, 1000, 0, "post_rst_row");

        for (int it = 0; it < 40; it++) begin
            if (it % 4 == 0) begin
                if ($urandom_range(0, 1) == 1)
                    load_filter(255, $urandom_range(200, 255), 255, $urandom_range(0, 255), 255);
                else
                    load_filter($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                                $urandom_range(0, 255), $urandom_range(0, 255));
            end
            run_row(5'($urandom_range(0, 31)), $urandom_range(0, PMAX), $urandom_range(0, 3), "rand");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pe_row_acc.md
PE_ROW_ACC -- requirements
Module: pe_row_acc

Interface
REQ-001 Parameter: WIDTH, 8, bit width of one unsigned filter weight.
REQ-002 Parameter: DEPTH_F, 5, weights per filter row and spike bits per window row.
REQ-003 Parameter: PACK_WIDTH, 64, width of one packed filter row word.
REQ-004 Parameter: PSUM_WIDTH, 13, partial-sum width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 filt_valid / filt_ready  in / out  1 / 1  packed filter row handshake.
REQ-008 filt_data  in  PACK_WIDTH  weight i = bits [WIDTH*i+WIDTH-1 : WIDTH*i], i=0..DEPTH_F-1; bits 63:40 ignored.
REQ-009 spk_valid / spk_ready  in / out  1 / 1  ifmap spike row handshake.
REQ-010 spk_data  in  DEPTH_F  bit i = spike at window column i.
REQ-011 psin_valid / psin_ready  in / out  1 / 1  upstream partial-sum handshake.
REQ-012 psin_data  in  PSUM_WIDTH  unsigned partial sum from previous row.
REQ-013 ps_valid / ps_ready  out / in  1 / 1  output partial-sum handshake.
REQ-014 ps_data  out  PSUM_WIDTH  unsigned partial sum result.
REQ-015 busy  out  1  high in ACC or OUT state.

Function
REQ-016 Transfer on any channel SHALL occur on a rising edge where valid and ready are both high; valid-driven data SHALL be held stable until transfer.
REQ-017 FSM states SHALL be IDLE (no weights), WREADY, ACC, OUT.
REQ-018 IDLE: filt_ready=1, spk_ready=0, psin_ready=0; filter transfer loads all DEPTH_F weights, goes to WREADY.
REQ-019 WREADY: filt_ready=1; spk_ready and psin_ready SHALL be high only when spk_valid and psin_valid are both high and filt_valid is low (joint transfer).
REQ-020 WREADY with filt_valid high SHALL give filter priority: weights replaced, state stays WREADY, no spike/psum transfer that cycle.
REQ-021 Joint spike+psum transfer SHALL latch spk_data, load accumulator with psin_data, reset column counter to 0, enter ACC.
REQ-022 ACC: one column per cycle, i=0..DEPTH_F-1; if spike bit i set, accumulator += weight i; after column DEPTH_F-1 enter OUT.
REQ-023 Addition SHALL saturate at 2^PSUM_WIDTH-1; no wrap-around.
REQ-024 OUT: ps_valid=1, ps_data=accumulator; on ps_ready return to WREADY; weights retained.
REQ-025 Latency: joint transfer at edge N -> ps_valid high after edge N+DEPTH_F (6 edges for DEPTH_F=5), independent of spike pattern.
REQ-026 filt_ready, spk_ready, psin_ready SHALL be low in ACC and OUT; filter reload mid-computation is impossible.
REQ-027 All-zero spike row SHALL produce ps_data = psin_data.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, weights 0, accumulator 0, counter 0, latched spikes 0.
REQ-029 During reset all valid/ready outputs and busy SHALL be 0, ps_data 0.
REQ-030 Reset mid-ACC or mid-OUT SHALL discard the pending result; no ps_valid after release until a new filter and spike row are transferred.

Structure
REQ-031 WIDTH, DEPTH_F, PACK_WIDTH, PSUM_WIDTH defaults and FSM state enum SHALL live in shared package snn_pkg.
REQ-032 Weight storage SHALL be a DEPTH_F-entry register array indexed by column counter; no sub-module required; optional sub-module sat_add for the saturating adder.

Verification
REQ-033 Load weights {1,2,3,4,5} (filt_data=0x0504030201), spk=5'b10101, psin=10 -> ps_data=19 after 6 edges.
REQ-034 Same weights, spk=5'b00000, psin=100 -> ps_data=100.
REQ-035 Weights all 255, spk=5'b11111, psin=8000 -> ps_data=8191 (saturated).
REQ-036 Hold ps_ready low 4 cycles in OUT -> ps_valid and ps_data stable; spk_ready/psin_ready low throughout.
REQ-037 In WREADY assert filt_valid (weights {10,10,10,10,10}) and spk/psin valid same cycle -> filter taken first; next cycle spk=5'b00011, psin=0 -> ps_data=20.
REQ-038 Assert rst_n low at ACC column 2 -> all outputs 0; after release spk_valid/psin_valid high produce no transfer until filter reloaded.
